// File: rtl/scramble_pkg.sv
// Shared types and helpers for the scramble sequencer: FSM state encoding,
// counter width and the line-index to one-hot decoder.
package scramble_pkg;

  localparam int MOVE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    FIRE  = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [3:0] line_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/scramble_sequencer_if.sv
// Player/random-source inputs and grid-control outputs of the scramble sequencer.
// The slave modport is the sequencer itself; master is whoever drives it.
interface scramble_sequencer_if;
  logic       scramble_req;
  logic [2:0] random_num;
  logic       user_fire;
  logic       user_nRow;
  logic [3:0] user_row_column;
  logic       user_error;
  logic       fire;
  logic       x_nRow;
  logic [3:0] row_column;
  logic       busy;
  logic       done;

  modport master (
    output scramble_req, random_num, user_fire, user_nRow, user_row_column, user_error,
    input  fire, x_nRow, row_column, busy, done
  );

  modport slave (
    input  scramble_req, random_num, user_fire, user_nRow, user_row_column, user_error,
    output fire, x_nRow, row_column, busy, done
  );
endinterface

// File: rtl/scramble_sequencer_gap_timer.sv
// Load/countdown/expire timer; expired is high on the last counted cycle so a
// load of N gives exactly N enabled cycles before the owner moves on.
module gap_timer
  import scramble_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [MOVE_W-1:0] load_val,
  output logic              expired
);

  logic [MOVE_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count <= MOVE_W'(1));

endmodule

// File: rtl/scramble_sequencer.sv
// Grid controller: passes the player's selection/fire through in user mode and
// runs NUM_MOVES pseudo-random fires on request. Define SCRAMBLE_NO_REPEAT_EN to
// make SETUP reject a move identical to the previous scramble move.
module scramble_sequencer
  import scramble_pkg::*;
#(
  parameter int unsigned NUM_MOVES  = 16,
  parameter int unsigned GAP_CYCLES = 15
) (
  input logic                 clk,
  input logic                 rst,
  scramble_sequencer_if.slave bus
);

  state_t            state;
  logic              fire_q;
  logic              nrow_q;
  logic [3:0]        line_q;
  logic              busy_q;
  logic              done_q;
  logic [MOVE_W-1:0] move_cnt;
  logic              timer_load;
  logic              timer_en;
  logic              timer_expired;
  logic [3:0]        sample_line;

`ifdef SCRAMBLE_NO_REPEAT_EN
  logic [4:0] prev_move;
  logic       prev_valid;
`endif

  assign sample_line = line_onehot(bus.random_num[1:0]);
  assign timer_load  = (state == FIRE) && (move_cnt != MOVE_W'(1));
  assign timer_en    = (state == GAP);

  gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (MOVE_W'(GAP_CYCLES)),
    .expired  (timer_expired)
  );

  // The random select is registered on entry to SETUP, so it is already on the
  // grid for the whole SETUP cycle and never changes together with fire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fire_q   <= 1'b0;
      nrow_q   <= 1'b0;
      line_q   <= 4'b0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      move_cnt <= '0;
`ifdef SCRAMBLE_NO_REPEAT_EN
      prev_move  <= '0;
      prev_valid <= 1'b0;
`endif
    end else begin
      fire_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.scramble_req) begin
            busy_q   <= 1'b1;
            move_cnt <= MOVE_W'(NUM_MOVES);
`ifdef SCRAMBLE_NO_REPEAT_EN
            prev_valid <= 1'b0;
`endif
            if (NUM_MOVES == 0) begin
              state  <= DONE;
              done_q <= 1'b1;
              line_q <= 4'b0000;
            end else begin
              state  <= SETUP;
              nrow_q <= bus.random_num[2];
              line_q <= sample_line;
            end
          end else begin
            nrow_q <= bus.user_nRow;
            line_q <= bus.user_row_column;
            fire_q <= bus.user_fire & ~bus.user_error;
          end
        end

        SETUP: begin
`ifdef SCRAMBLE_NO_REPEAT_EN
          if (prev_valid && prev_move == {nrow_q, line_q}) begin
            nrow_q <= bus.random_num[2];
            line_q <= sample_line;
          end else begin
            state      <= FIRE;
            fire_q     <= 1'b1;
            prev_move  <= {nrow_q, line_q};
            prev_valid <= 1'b1;
          end
`else
          state  <= FIRE;
          fire_q <= 1'b1;
`endif
        end

        FIRE: begin
          move_cnt <= move_cnt - 1'b1;
          if (move_cnt == MOVE_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            line_q <= 4'b0000;
          end else begin
            state <= GAP;
          end
        end

        GAP: begin
          if (timer_expired) begin
            state  <= SETUP;
            nrow_q <= bus.random_num[2];
            line_q <= sample_line;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fire       = fire_q;
  assign bus.x_nRow     = nrow_q;
  assign bus.row_column = line_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
